// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 operation codes, FSM state encoding and
// operand-signedness decode used by the iterative multiply/divide unit.
package riscv_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // Returns {in1 signed, in2 signed} for the given operation.
   function automatic logic [1:0] is_signed(input logic [2:0] op);
      case (op)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: return 2'b11;
         MD_MULHSU:                       return 2'b10;
         default:                         return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      md_op;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] out;
   logic            zero;

   modport master (
      output start, md_op, in1, in2,
      input  busy, done, out, zero
   );

   modport slave (
      input  start, md_op, in1, in2,
      output busy, done, out, zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle over a shared 2*XLEN
// accumulator, with a single-cycle fast path for divide-by-zero and overflow.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   md_state_t         state;
   md_state_t         state_next;
   logic [CW-1:0]     cnt;
   logic [XLEN-1:0]   out_r;
   logic              zero_r;

   logic [2:0]        op_r;
   logic [XLEN-1:0]   mag1;
   logic [XLEN-1:0]   mag2;
   logic              neg_res;
   logic              neg_rem;
   logic [2*XLEN-1:0] acc;

   // Accept-time operand decode
   logic            accept;
   logic [1:0]      sgn;
   logic            s1;
   logic            s2;
   logic [XLEN-1:0] in_mag1;
   logic [XLEN-1:0] in_mag2;
   logic            div_zero;
   logic            div_ovf;
   logic            fast;
   logic [XLEN-1:0] fast_val;

   assign accept   = (state == ST_IDLE) && bus.start;
   assign sgn      = is_signed(bus.md_op);
   assign s1       = sgn[1] & bus.in1[XLEN-1];
   assign s2       = sgn[0] & bus.in2[XLEN-1];
   assign in_mag1  = neg_if(bus.in1, s1);
   assign in_mag2  = neg_if(bus.in2, s2);
   assign div_zero = is_div(bus.md_op) && (bus.in2 == '0);
   assign div_ovf  = ((bus.md_op == MD_DIV) || (bus.md_op == MD_REM)) &&
                     (bus.in1 == MOST_NEG) && (bus.in2 == '1);
   assign fast     = div_zero || div_ovf;

   // md_op[1] separates REM/REMU from DIV/DIVU within the divide group.
   always_comb begin
      fast_val = '0;
      if (div_zero) begin
         fast_val = bus.md_op[1] ? bus.in1 : '1;
      end else begin
         fast_val = bus.md_op[1] ? '0 : bus.in1;
      end
   end

   // One iteration of shift-add multiply or restoring divide
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] acc_step;

   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag1 : {XLEN{1'b0}})};
   assign mul_next = {mul_sum, acc[XLEN-1:1]};
   assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mag2};
   assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign acc_step = is_div(op_r) ? div_next : mul_next;

   // Sign fix-up of the final iteration, written straight into out
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   calc_res;

   assign prod = neg_if_w(acc_step, neg_res);
   assign quo  = neg_if(acc_step[XLEN-1:0], neg_res);
   assign rem  = neg_if(acc_step[2*XLEN-1:XLEN], neg_rem);

   always_comb begin
      calc_res = '0;
      if (is_div(op_r)) begin
         calc_res = op_r[1] ? rem : quo;
      end else begin
         calc_res = (op_r == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (bus.start) state_next = fast ? ST_DONE : ST_CALC;
         ST_CALC: if (cnt == '0) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         out_r  <= '0;
         zero_r <= 1'b1;
      end else if (accept) begin
         cnt <= CW'(XLEN - 1);
         if (fast) begin
            out_r  <= fast_val;
            zero_r <= (fast_val == '0);
         end
      end else if (state == ST_CALC) begin
         if (cnt == '0) begin
            out_r  <= calc_res;
            zero_r <= (calc_res == '0);
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Operands and accumulator need no reset: they are reloaded on every accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r    <= bus.md_op;
         mag1    <= in_mag1;
         mag2    <= in_mag2;
         neg_res <= s1 ^ s2;
         neg_rem <= s1;
         acc     <= is_div(bus.md_op) ? {{XLEN{1'b0}}, in_mag1} : {{XLEN{1'b0}}, in_mag2};
      end else if (state == ST_CALC) begin
         acc <= acc_step;
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.out  = out_r;
   assign bus.zero = zero_r;

endmodule
